// File: rtl/bias_buffer_loader_if.sv
// Stream-in / buffer-write bundle for the bias buffer loader.
//
// Handshake: an input beat transfers on a rising clk edge where
// in_valid && in_ready are both high; in_data must be stable while in_valid
// is high and in_ready is low, and in_ready never depends on in_valid.
// bs_write_req is fire-and-forget: every set bit is a completed write in
// that cycle, with bs_write_addr/bs_write_data qualifying it.
interface bias_buffer_loader_if #(
  parameter int DDR_BANDWIDTH    = 512,
  parameter int NUM_BANKS        = 64,
  parameter int WRITE_ADDR_WIDTH = 8
);
  logic                                  in_valid;
  logic [DDR_BANDWIDTH-1:0]              in_data;
  logic                                  in_ready;
  logic [NUM_BANKS-1:0]                  bs_write_req;
  logic [NUM_BANKS*WRITE_ADDR_WIDTH-1:0] bs_write_addr;
  logic [DDR_BANDWIDTH-1:0]              bs_write_data;

  // loader side: consumes the beat stream, drives the buffer write port
  modport slave (
    input  in_valid, in_data,
    output in_ready, bs_write_req, bs_write_addr, bs_write_data
  );

  // environment side: produces beats, observes the buffer write port
  modport master (
    output in_valid, in_data,
    input  in_ready, bs_write_req, bs_write_addr, bs_write_data
  );
endinterface

// File: rtl/bias_buffer_loader.sv
// Bias buffer loader: takes DDR-width beats and writes them into the banked
// bias buffer, BANKS_PER_BEAT banks per beat, BEATS_PER_ROW beats per row.
module bias_buffer_loader #(
  parameter int DDR_BANDWIDTH    = 512,
  parameter int NUM_BANKS        = 64,
  parameter int WRITE_WIDTH      = 32,
  parameter int WRITE_ADDR_WIDTH = 8,
  parameter int ROW_CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        clear,
  input  logic [WRITE_ADDR_WIDTH-1:0] base_addr,
  input  logic [ROW_CNT_WIDTH-1:0]    num_rows,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  dbg_state,
  bias_buffer_loader_if.slave         bus
);

  localparam int BANKS_PER_BEAT = DDR_BANDWIDTH / WRITE_WIDTH;
  localparam int BEATS_PER_ROW  = NUM_BANKS / BANKS_PER_BEAT;
  localparam int BEAT_W         = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(BEATS_PER_ROW - 1);
  localparam logic [ROW_CNT_WIDTH-1:0] ONE_ROW   = ROW_CNT_WIDTH'(1);

  generate
    if (DDR_BANDWIDTH % WRITE_WIDTH != 0) begin : g_bad_beat_width
      $error("DDR_BANDWIDTH must be a multiple of WRITE_WIDTH");
    end
    if (NUM_BANKS % BANKS_PER_BEAT != 0) begin : g_bad_bank_count
      $error("NUM_BANKS must be a multiple of DDR_BANDWIDTH/WRITE_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BEAT_W-1:0]                     beat_cnt_q, beat_cnt_d;
  logic [WRITE_ADDR_WIDTH-1:0]           row_addr_q, row_addr_d;
  logic [ROW_CNT_WIDTH-1:0]              rows_left_q, rows_left_d;
  logic [NUM_BANKS-1:0]                  bs_write_req_q, bs_write_req_d;
  logic [NUM_BANKS*WRITE_ADDR_WIDTH-1:0] bs_write_addr_q, bs_write_addr_d;
  logic [DDR_BANDWIDTH-1:0]              bs_write_data_q, bs_write_data_d;

  logic in_ready_o;
  logic accept;
  logic last_beat;

  assign accept    = bus.in_valid & in_ready_o;
  assign last_beat = (beat_cnt_q == LAST_BEAT) && (rows_left_q == ONE_ROW);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; clear wins over everything, including start
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = (num_rows == '0) ? FINISH : LOAD;
        LOAD:    if (accept && last_beat) state_d = FINISH;
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs, decoded purely from state
  always_comb begin
    in_ready_o = (state_q == LOAD);
    busy       = (state_q != IDLE);
    done       = (state_q == FINISH);
  end

  // Row/beat sequencing and one-cycle-late registration of each accepted beat
  always_comb begin
    beat_cnt_d      = beat_cnt_q;
    row_addr_d      = row_addr_q;
    rows_left_d     = rows_left_q;
    bs_write_req_d  = '0;
    bs_write_addr_d = bs_write_addr_q;
    bs_write_data_d = bs_write_data_q;

    // an accept in a clear cycle still becomes a write next cycle
    if (accept) begin
      for (int b = 0; b < BEATS_PER_ROW; b++) begin
        if (beat_cnt_q == BEAT_W'(b)) begin
          bs_write_req_d[b*BANKS_PER_BEAT +: BANKS_PER_BEAT] = '1;
        end
      end
      bs_write_addr_d = {NUM_BANKS{row_addr_q}};
      bs_write_data_d = bus.in_data;
    end

    if (clear) begin
      beat_cnt_d  = '0;
      row_addr_d  = '0;
      rows_left_d = '0;
    end else if (state_q == IDLE && start && num_rows != '0) begin
      beat_cnt_d  = '0;
      row_addr_d  = base_addr;
      rows_left_d = num_rows;
    end else if (accept) begin
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d  = '0;
        row_addr_d  = row_addr_q + 1'b1;
        rows_left_d = rows_left_q - 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_q      <= '0;
      row_addr_q      <= '0;
      rows_left_q     <= '0;
      bs_write_req_q  <= '0;
      bs_write_addr_q <= '0;
      bs_write_data_q <= '0;
    end else begin
      beat_cnt_q      <= beat_cnt_d;
      row_addr_q      <= row_addr_d;
      rows_left_q     <= rows_left_d;
      bs_write_req_q  <= bs_write_req_d;
      bs_write_addr_q <= bs_write_addr_d;
      bs_write_data_q <= bs_write_data_d;
    end
  end

  assign bus.in_ready      = in_ready_o;
  assign bus.bs_write_req  = bs_write_req_q;
  assign bus.bs_write_addr = bs_write_addr_q;
  assign bus.bs_write_data = bs_write_data_q;
  assign dbg_state         = state_q;

endmodule
